// File: rtl/sbox_lane_arbiter.sv
// rtl/sbox_lane_arbiter.sv - shares one 32-bit S-box lane between a 128-bit state request and a 32-bit key request
// Optional macro SBOX_LANE_REG_EN registers lane_out before capture (adds one cycle per job).
module sbox_lane_arbiter #(
  parameter int WORD_W   = 32,
  parameter int ST_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [WORD_W*ST_WORDS-1:0] st_data,
  output logic                       st_done,
  output logic [WORD_W*ST_WORDS-1:0] st_result,
  input  logic                       key_valid,
  output logic                       key_ready,
  input  logic [WORD_W-1:0]          key_data,
  output logic                       key_done,
  output logic [WORD_W-1:0]          key_result,
  output logic [WORD_W-1:0]          lane_in,
  input  logic [WORD_W-1:0]          lane_out,
  output logic                       busy
);

  generate
    if (WORD_W != 32 || ST_WORDS != 4) begin : g_bad_cfg
      $error("sbox_lane_arbiter: WORD_W must be 32 and ST_WORDS must be 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_ST,
    S_RUN_KEY,
    S_DONE_ST,
    S_DONE_KEY
  } state_t;

  state_t            r_state;
  logic              r_rr;
  logic [WORD_W-1:0] r_st_buf [ST_WORDS];
  logic [WORD_W-1:0] r_st_res [ST_WORDS];
  logic [WORD_W-1:0] r_key_buf;
  logic [WORD_W-1:0] r_key_res;

  logic [WORD_W-1:0] w_cap;
  logic [1:0]        w_lane_idx;
  logic [1:0]        w_cap_idx;
  logic              w_lane_vld;
  logic              w_cap_en;
  logic              w_st_last;
  logic              w_key_last;
  logic              w_idle;
  logic              w_grant_st;
  logic              w_grant_key;

`ifdef SBOX_LANE_REG_EN
  // One extra count step: capture index trails the lane word by one cycle.
  localparam int CNT_W = 3;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_lane_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lane_q <= '0;
    else     r_lane_q <= lane_out;
  end

  assign w_cap      = r_lane_q;
  assign w_lane_idx = r_cnt[1:0];
  assign w_lane_vld = ~r_cnt[2];
  assign w_cap_en   = (r_cnt != 3'd0);
  assign w_cap_idx  = 2'(r_cnt - 3'd1);
  assign w_st_last  = (r_cnt == 3'd4);
  assign w_key_last = r_cnt[0];
`else
  localparam int CNT_W = 2;
  logic [CNT_W-1:0]  r_cnt;

  assign w_cap      = lane_out;
  assign w_lane_idx = r_cnt;
  assign w_lane_vld = 1'b1;
  assign w_cap_en   = 1'b1;
  assign w_cap_idx  = r_cnt;
  assign w_st_last  = (r_cnt == 2'd3);
  assign w_key_last = 1'b1;
`endif

  // On a tie only the requester favoured by rr sees ready.
  assign w_idle      = (r_state == S_IDLE) & ~rst;
  assign st_ready    = w_idle & ~(st_valid & key_valid & ~r_rr);
  assign key_ready   = w_idle & ~(st_valid & key_valid & r_rr);
  assign w_grant_st  = st_valid & st_ready;
  assign w_grant_key = key_valid & key_ready;

  assign st_done    = (r_state == S_DONE_ST);
  assign key_done   = (r_state == S_DONE_KEY);
  assign busy       = (r_state != S_IDLE);
  assign key_result = r_key_res;

  for (genvar g = 0; g < ST_WORDS; g++) begin : g_pack
    assign st_result[(ST_WORDS-1-g)*WORD_W +: WORD_W] = r_st_res[g];
  end

  always_comb begin
    lane_in = '0;
    case (r_state)
      S_RUN_ST:  if (w_lane_vld) lane_in = r_st_buf[w_lane_idx];
      S_RUN_KEY: lane_in = r_key_buf;
      default:   lane_in = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rr      <= 1'b0;
      r_key_buf <= '0;
      r_key_res <= '0;
      for (int i = 0; i < ST_WORDS; i++) begin
        r_st_buf[i] <= '0;
        r_st_res[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_key) begin
            r_key_buf <= key_data;
            r_rr      <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_RUN_KEY;
          end else if (w_grant_st) begin
            for (int i = 0; i < ST_WORDS; i++)
              r_st_buf[i] <= st_data[(ST_WORDS-1-i)*WORD_W +: WORD_W];
            r_rr    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN_ST;
          end
        end
        S_RUN_ST: begin
          if (w_cap_en) r_st_res[w_cap_idx] <= w_cap;
          if (w_st_last) begin
            r_cnt   <= '0;
            r_state <= S_DONE_ST;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RUN_KEY: begin
          if (w_key_last) begin
            r_key_res <= w_cap;
            r_cnt     <= '0;
            r_state   <= S_DONE_KEY;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE_ST, S_DONE_KEY: r_state <= S_IDLE;
        default:               r_state <= S_IDLE;
      endcase
    end
  end

endmodule
